ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard receiver; consumes its 8-bit scan-set-2 codes.
- Tracks the make/break prefixes F0 and E0 and the shift state, and translates make codes to ASCII.
- Buffers the characters in a FIFO that the CPU bus interface reads one byte at a time.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- fclk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset.
- code_valid  input  1  one-cycle strobe; code_in is valid this cycle.
- code_in  input  8  scan code from the receiver.
- rd  input  1  one-cycle pop strobe from the bus; ignored when empty.
- key_data  output  8  ASCII at FIFO head (show-ahead); 0x00 when empty.
- key_ready  output  1  FIFO non-empty.
- fifo_full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; a character was dropped because the FIFO was full.
- shift_state  output  1  current shift state (left or right shift held).

Behaviour:
- Reset (rst=0 at a posedge):
  - FSM to IDLE; shift flags cleared; FIFO pointers and count set to 0.
  - Outputs: key_ready=0, fifo_full=0, overflow=0, key_data=0x00, shift_state=0.
  - Reset overrides any partial prefix sequence.
- FSM states: IDLE, BRK, EXT, EXT_BRK. A transition occurs only on an edge with code_valid=1.
  - IDLE: F0 -> BRK; E0 -> EXT; 12 or 59 sets lshift or rshift; any other code is a make code and goes to translation.
  - BRK: 12 or 59 clears lshift or rshift; every other code is discarded. Next state IDLE.
  - EXT: F0 -> EXT_BRK; any other code is discarded, including E0 12 (fake shift), and the state returns to IDLE.
  - EXT_BRK: discard the code; go to IDLE.
  - A repeated E0 in IDLE or EXT is treated as entering EXT.
  - shift_state = lshift OR rshift.
- Translation (registered stage, shift sampled at the same edge as the code):
  - Letters 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A map to a..z (0x61..0x7A); with shift they map to A..Z (0x41..0x5A).
  - Digits 45 16 1E 26 25 2E 36 3D 3E 46 map to 0..9 (0x30..0x39); with shift they map to ) ! @ # $ % ^ & * ( respectively.
  - Fixed codes, independent of shift: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 0D -> 0x09, 76 -> 0x1B.
  - Any other make code is dropped; nothing is written.
  - Typematic repeats (a make code with no intervening break) each produce a character.
- Latency:
  - code_valid sampled at edge N; FIFO write at edge N+1.
  - key_ready/key_data reflect the new entry after edge N+1 when the FIFO was empty.
  - code_valid on consecutive cycles is fully pipelined; one code is accepted per cycle.
- FIFO:
  - Circular buffer; write and read pointers AW bits wide, wrapping naturally; count AW+1 bits wide.
  - rd=1 with key_ready=1 pops at the edge; rd=1 with empty FIFO is a no-op.
  - Write with a simultaneous pop when full: both occur; count unchanged; no overflow.
  - Write with a simultaneous pop when empty: the write occurs; the pop is ignored because the FIFO was empty at the edge.
  - Write when full without a pop: the character is discarded, overflow is set, and FIFO contents are unchanged.
  - overflow clears only on reset.

Optional Feature:
- Macro: PS2_CAPSLOCK_EN.
- Defined:
  - Make code 58 toggles a caps register (reset 0); it is not enqueued. Break F0 58 has no effect.
  - Letter case = shift XOR caps. Digits and symbols follow shift only.
  - Extra output port caps_state (1 bit) reports the caps register.
- Undefined:
  - 58 is an unmapped make code and is dropped.
  - No caps register and no caps_state port.

Test Plan:
1. Reset, then code 1C -> one entry 0x61; key_ready=1 two edges after the strobe; rd pops; key_ready=0, key_data=0x00.
2. Sequence 12, 1C, F0 12, 1C -> FIFO holds 0x41 then 0x61; shift_state 1 then 0; the break code yields no entry.
3. Sequence E0 12, 1C, then E0 F0 12 -> shift_state stays 0; only 0x61 is enqueued; E0 75 (arrow) enqueues nothing.
4. Nine make codes 16 with no reads -> fifo_full=1 after the 8th write; the 9th sets overflow=1; draining yields eight 0x31; overflow stays 1.
5. FIFO full, rd and a 1E make strobe arrive in the same cycle -> count stays 8; the last entry read is 0x32; overflow stays 0.
6. Feed F0, assert rst=0 for one cycle, then send 1C -> 0x61 is enqueued (the pending break is discarded by reset). With PS2_CAPSLOCK_EN defined: 58, 1C, 12, 1C -> 0x41 then 0x61, caps_state=1.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-set-2 decoder: prefix/shift FSM, ASCII translation, FIFO.
// Ports: fclk, rst (sync low), code_valid/code_in, rd, key_data,
//   key_ready, fifo_full, overflow, shift_state[, caps_state].
// Optional: define PS2_CAPSLOCK_EN for caps lock (code 58) support.
module ps2_key_decoder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code_in,
    input  logic       rd,
    output logic [7:0] key_data,
    output logic       key_ready,
    output logic       fifo_full,
    output logic       overflow,
    output logic       shift_state
`ifdef PS2_CAPSLOCK_EN
    ,
    output logic       caps_state
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_e;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_e      state_q;
    logic        lshift_q;
    logic        rshift_q;
    logic        caps_q;
    logic        wr_v_q;
    logic [7:0]  wr_data_q;

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0] count_q;
    logic        ovf_q;

    logic        shift;
    logic        upper;
    logic        is_letter;
    logic        is_digit;
    logic        is_fixed;
    logic [4:0]  lidx;
    logic [3:0]  didx;
    logic [7:0]  fixed_char;
    logic [7:0]  sym_char;
    logic [7:0]  tr_char;
    logic        tr_hit;
    logic        is_ctrl;
    logic        make_ok;

    assign shift = lshift_q | rshift_q;

`ifdef PS2_CAPSLOCK_EN
    assign upper   = shift ^ caps_q;
    assign is_ctrl = (code_in == 8'hF0) || (code_in == 8'hE0) ||
                     (code_in == 8'h12) || (code_in == 8'h59) ||
                     (code_in == 8'h58);
`else
    assign upper   = shift;
    assign is_ctrl = (code_in == 8'hF0) || (code_in == 8'hE0) ||
                     (code_in == 8'h12) || (code_in == 8'h59);
`endif

    // Code lookup: letters and digits resolve to an index so the
    // output character is a simple base + offset.
    always_comb begin
        is_letter  = 1'b0;
        is_digit   = 1'b0;
        is_fixed   = 1'b0;
        lidx       = 5'd0;
        didx       = 4'd0;
        fixed_char = 8'h00;
        case (code_in)
            8'h1C: begin is_letter = 1'b1; lidx = 5'd0;  end
            8'h32: begin is_letter = 1'b1; lidx = 5'd1;  end
            8'h21: begin is_letter = 1'b1; lidx = 5'd2;  end
            8'h23: begin is_letter = 1'b1; lidx = 5'd3;  end
            8'h24: begin is_letter = 1'b1; lidx = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; lidx = 5'd5;  end
            8'h34: begin is_letter = 1'b1; lidx = 5'd6;  end
            8'h33: begin is_letter = 1'b1; lidx = 5'd7;  end
            8'h43: begin is_letter = 1'b1; lidx = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; lidx = 5'd9;  end
            8'h42: begin is_letter = 1'b1; lidx = 5'd10; end
            8'h4B: begin is_letter = 1'b1; lidx = 5'd11; end
            8'h3A: begin is_letter = 1'b1; lidx = 5'd12; end
            8'h31: begin is_letter = 1'b1; lidx = 5'd13; end
            8'h44: begin is_letter = 1'b1; lidx = 5'd14; end
            8'h4D: begin is_letter = 1'b1; lidx = 5'd15; end
            8'h15: begin is_letter = 1'b1; lidx = 5'd16; end
            8'h2D: begin is_letter = 1'b1; lidx = 5'd17; end
            8'h1B: begin is_letter = 1'b1; lidx = 5'd18; end
            8'h2C: begin is_letter = 1'b1; lidx = 5'd19; end
            8'h3C: begin is_letter = 1'b1; lidx = 5'd20; end
            8'h2A: begin is_letter = 1'b1; lidx = 5'd21; end
            8'h1D: begin is_letter = 1'b1; lidx = 5'd22; end
            8'h22: begin is_letter = 1'b1; lidx = 5'd23; end
            8'h35: begin is_letter = 1'b1; lidx = 5'd24; end
            8'h1A: begin is_letter = 1'b1; lidx = 5'd25; end
            8'h45: begin is_digit = 1'b1; didx = 4'd0; end
            8'h16: begin is_digit = 1'b1; didx = 4'd1; end
            8'h1E: begin is_digit = 1'b1; didx = 4'd2; end
            8'h26: begin is_digit = 1'b1; didx = 4'd3; end
            8'h25: begin is_digit = 1'b1; didx = 4'd4; end
            8'h2E: begin is_digit = 1'b1; didx = 4'd5; end
            8'h36: begin is_digit = 1'b1; didx = 4'd6; end
            8'h3D: begin is_digit = 1'b1; didx = 4'd7; end
            8'h3E: begin is_digit = 1'b1; didx = 4'd8; end
            8'h46: begin is_digit = 1'b1; didx = 4'd9; end
            8'h29: begin is_fixed = 1'b1; fixed_char = 8'h20; end
            8'h5A: begin is_fixed = 1'b1; fixed_char = 8'h0D; end
            8'h66: begin is_fixed = 1'b1; fixed_char = 8'h08; end
            8'h0D: begin is_fixed = 1'b1; fixed_char = 8'h09; end
            8'h76: begin is_fixed = 1'b1; fixed_char = 8'h1B; end
            default: ;
        endcase
    end

    always_comb begin
        sym_char = 8'h29;
        case (didx)
            4'd1:    sym_char = 8'h21;
            4'd2:    sym_char = 8'h40;
            4'd3:    sym_char = 8'h23;
            4'd4:    sym_char = 8'h24;
            4'd5:    sym_char = 8'h25;
            4'd6:    sym_char = 8'h5E;
            4'd7:    sym_char = 8'h26;
            4'd8:    sym_char = 8'h2A;
            4'd9:    sym_char = 8'h28;
            default: sym_char = 8'h29;
        endcase
    end

    always_comb begin
        tr_char = fixed_char;
        if (is_letter) begin
            tr_char = (upper ? 8'h41 : 8'h61) + {3'b000, lidx};
        end else if (is_digit) begin
            tr_char = shift ? sym_char : 8'h30 + {4'b0000, didx};
        end
    end

    assign tr_hit  = is_letter | is_digit | is_fixed;
    assign make_ok = code_valid && (state_q == IDLE) && !is_ctrl;

    always_ff @(posedge fclk) begin
        if (!rst) begin
            state_q   <= IDLE;
            lshift_q  <= 1'b0;
            rshift_q  <= 1'b0;
            caps_q    <= 1'b0;
            wr_v_q    <= 1'b0;
            wr_data_q <= 8'h00;
        end else begin
            wr_v_q    <= make_ok & tr_hit;
            wr_data_q <= tr_char;
            if (code_valid) begin
                unique case (state_q)
                    IDLE: begin
                        case (code_in)
                            8'hF0: state_q  <= BRK;
                            8'hE0: state_q  <= EXT;
                            8'h12: lshift_q <= 1'b1;
                            8'h59: rshift_q <= 1'b1;
`ifdef PS2_CAPSLOCK_EN
                            8'h58: caps_q   <= ~caps_q;
`endif
                            default: ;
                        endcase
                    end
                    BRK: begin
                        if (code_in == 8'h12) lshift_q <= 1'b0;
                        if (code_in == 8'h59) rshift_q <= 1'b0;
                        state_q <= IDLE;
                    end
                    EXT: begin
                        case (code_in)
                            8'hF0:   state_q <= EXT_BRK;
                            8'hE0:   state_q <= EXT;
                            default: state_q <= IDLE;
                        endcase
                    end
                    EXT_BRK: state_q <= IDLE;
                endcase
            end
        end
    end

    logic full;
    logic pop;
    logic push;

    assign full = (count_q == FULL_CNT);
    assign pop  = rd && (count_q != '0);
    // A pop on the same edge frees the slot a full-FIFO write needs.
    assign push = wr_v_q && (!full || pop);

    always_ff @(posedge fclk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_v_q && !push) ovf_q <= 1'b1;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge fclk) begin
        if (push) mem_q[wptr_q] <= wr_data_q;
    end

    assign key_ready   = (count_q != '0);
    assign key_data    = key_ready ? mem_q[rptr_q] : 8'h00;
    assign fifo_full   = full;
    assign overflow    = ovf_q;
    assign shift_state = shift;
`ifdef PS2_CAPSLOCK_EN
    assign caps_state  = caps_q;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized bench for ps2_key_decoder with a queue-based key model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;

    logic       fclk = 1'b0;
    logic       rst = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] key_data;
    logic       key_ready;
    logic       fifo_full;
    logic       overflow;
    logic       shift_state;
`ifdef PS2_CAPSLOCK_EN
    logic       caps_state;
`endif

    ps2_key_decoder #(.DEPTH(DEPTH), .AW(3)) dut (
        .fclk        (fclk),
        .rst         (rst),
        .code_valid  (code_valid),
        .code_in     (code_in),
        .rd          (rd),
        .key_data    (key_data),
        .key_ready   (key_ready),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .shift_state (shift_state)
`ifdef PS2_CAPSLOCK_EN
        ,
        .caps_state  (caps_state)
`endif
    );

    always #5 fclk = ~fclk;

    logic [7:0] letters [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] syms [10] = '{
        8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    logic [7:0] fcodes [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
    logic [7:0] fchars [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

    // Model: pending-prefix flags, shift keys, a one-deep translate
    // pipe and the character queue.
    logic [7:0] q [$];
    bit         pf0, pe0, ls, rs, caps, ovf, pv;
    logic [7:0] pc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    task automatic xlate(input logic [7:0] c, output bit hit,
                         output logic [7:0] ch);
        bit sh;
        bit up;
        sh  = ls | rs;
        up  = sh;
`ifdef PS2_CAPSLOCK_EN
        up  = sh ^ caps;
`endif
        hit = 1'b0;
        ch  = 8'h00;
        for (int i = 0; i < 26; i++)
            if (c == letters[i]) begin
                hit = 1'b1;
                ch  = 8'((up ? 65 : 97) + i);
            end
        for (int i = 0; i < 10; i++)
            if (c == digits[i]) begin
                hit = 1'b1;
                ch  = sh ? syms[i] : 8'(48 + i);
            end
        for (int i = 0; i < 5; i++)
            if (c == fcodes[i]) begin
                hit = 1'b1;
                ch  = fchars[i];
            end
    endtask

    task automatic model_step(input logic r, input logic cv,
                              input logic [7:0] c, input logic rdi);
        bit         p;
        bit         hit;
        logic [7:0] ch;
        logic [7:0] dummy;
        if (!r) begin
            q.delete();
            pf0 = 0; pe0 = 0; ls = 0; rs = 0;
            caps = 0; ovf = 0; pv = 0;
            return;
        end
        p = rdi && (q.size() > 0);
        if (p) dummy = q.pop_front();
        if (pv) begin
            if (q.size() >= DEPTH) ovf = 1;
            else q.push_back(pc);
        end
        pv = 0;
        if (cv) begin
            if (pe0 && pf0) begin
                pe0 = 0; pf0 = 0;
            end else if (pf0) begin
                if (c == 8'h12) ls = 0;
                if (c == 8'h59) rs = 0;
                pf0 = 0;
            end else if (pe0) begin
                if (c == 8'hF0) pf0 = 1;
                else if (c != 8'hE0) pe0 = 0;
            end else if (c == 8'hF0) pf0 = 1;
            else if (c == 8'hE0) pe0 = 1;
            else if (c == 8'h12) ls = 1;
            else if (c == 8'h59) rs = 1;
`ifdef PS2_CAPSLOCK_EN
            else if (c == 8'h58) caps = ~caps;
`endif
            else begin
                xlate(c, hit, ch);
                pv = hit;
                pc = ch;
            end
        end
    endtask

    // Drive at negedge, model at posedge, compare at next negedge.
    task automatic cyc(input logic r, input logic cv,
                       input logic [7:0] c, input logic rdi);
        rst = r; code_valid = cv; code_in = c; rd = rdi;
        @(posedge fclk);
        model_step(r, cv, c, rdi);
        @(negedge fclk);
        chk("key_ready", {7'd0, key_ready}, {7'd0, q.size() > 0});
        chk("key_data", key_data, (q.size() > 0) ? q[0] : 8'h00);
        chk("fifo_full", {7'd0, fifo_full}, {7'd0, q.size() == DEPTH});
        chk("overflow", {7'd0, overflow}, {7'd0, ovf});
        chk("shift_state", {7'd0, shift_state}, {7'd0, ls | rs});
`ifdef PS2_CAPSLOCK_EN
        chk("caps_state", {7'd0, caps_state}, {7'd0, caps});
`endif
    endtask

    task automatic key(input logic [7:0] c);
        cyc(1'b1, 1'b1, c, 1'b0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic pop1();
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
    endtask
    task automatic reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] rnd_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return 8'hF0;
        if (r < 16) return 8'hE0;
        if (r < 22) return 8'h12;
        if (r < 27) return 8'h59;
        if (r < 30) return 8'h58;
        if (r < 60) return letters[$urandom_range(0, 25)];
        if (r < 78) return digits[$urandom_range(0, 9)];
        if (r < 85) return fcodes[$urandom_range(0, 4)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        @(negedge fclk);
        reset();
        chk("t1_rst_ready", {7'd0, key_ready}, 8'h00);
        chk("t1_rst_data", key_data, 8'h00);
        key(8'h1C);
        chk("t1_lat_ready", {7'd0, key_ready}, 8'h00);
        idle(1);
        chk("t1_ready", {7'd0, key_ready}, 8'h01);
        chk("t1_data", key_data, 8'h61);
        pop1();
        chk("t1_pop_ready", {7'd0, key_ready}, 8'h00);
        chk("t1_pop_data", key_data, 8'h00);

        key(8'h12);
        chk("t2_shift1", {7'd0, shift_state}, 8'h01);
        key(8'h1C); key(8'hF0); key(8'h12);
        chk("t2_shift0", {7'd0, shift_state}, 8'h00);
        key(8'h1C); idle(2);
        chk("t2_first", key_data, 8'h41);
        pop1();
        chk("t2_second", key_data, 8'h61);
        pop1();
        chk("t2_empty", {7'd0, key_ready}, 8'h00);

        key(8'hE0); key(8'h12); key(8'h1C);
        key(8'hE0); key(8'hF0); key(8'h12);
        key(8'hE0); key(8'h75); idle(2);
        chk("t3_shift", {7'd0, shift_state}, 8'h00);
        chk("t3_data", key_data, 8'h61);
        pop1();
        chk("t3_only", {7'd0, key_ready}, 8'h00);

        for (int i = 0; i < 9; i++) key(8'h16);
        idle(1);
        chk("t4_full", {7'd0, fifo_full}, 8'h01);
        chk("t4_ovf", {7'd0, overflow}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain", key_data, 8'h31);
            pop1();
        end
        chk("t4_ovf_sticky", {7'd0, overflow}, 8'h01);

        reset();
        for (int i = 0; i < 8; i++) key(8'h16);
        idle(1);
        chk("t5_full", {7'd0, fifo_full}, 8'h01);
        cyc(1'b1, 1'b1, 8'h1E, 1'b1);
        idle(1);
        chk("t5_still_full", {7'd0, fifo_full}, 8'h01);
        for (int i = 0; i < 7; i++) pop1();
        chk("t5_last", key_data, 8'h32);
        chk("t5_no_ovf", {7'd0, overflow}, 8'h00);
        pop1();

        key(8'hF0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        key(8'h1C); idle(1);
        chk("t6_data", key_data, 8'h61);
        pop1();

`ifdef PS2_CAPSLOCK_EN
        key(8'h58); key(8'h1C); key(8'h12); key(8'h1C); idle(1);
        chk("t7_caps", {7'd0, caps_state}, 8'h01);
        chk("t7_first", key_data, 8'h41);
        pop1();
        chk("t7_second", key_data, 8'h61);
        key(8'hF0); key(8'h12); pop1(); key(8'hF0); key(8'h58);
        key(8'h58); idle(1);
`endif

        reset();
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic cv;
            logic rdi;
            r   = ($urandom_range(0, 199) != 0);
            cv  = ($urandom_range(0, 99) < 60);
            rdi = ($urandom_range(0, 99) < 30);
            cyc(r, cv, cv ? rnd_code() : 8'h00, rdi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
